// File: rtl/otf_pkg.sv
// Shared definitions for the on-the-fly signed-digit converter and the divider digit logic.
// Digit encoding is {plus, minus}; 2'b11 is not a legal digit.
package otf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } otf_state_t;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_ILL  = 2'b11;

endpackage

// File: rtl/otf_sd_update.sv
// Next-Q/next-QM selection for one radix-2 signed digit, MSB shifted out and dropped.
// Latency: purely combinational. Backpressure: none, the caller decides when to register.
// Illegal digit 2'b11 falls into the zero branch.
module otf_sd_update
  import otf_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_nxt,
  output logic [W-1:0] qm_nxt
);

  always_comb begin
    q_nxt  = (q << 1);
    qm_nxt = (qm << 1) | W'(1);
    case (digit)
      SD_POS: begin
        q_nxt  = (q << 1) | W'(1);
        qm_nxt = (q << 1);
      end
      SD_NEG: begin
        q_nxt  = (qm << 1) | W'(1);
        qm_nxt = (qm << 1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/otf_sd_converter.sv
// MSD-first signed-digit quotient to two's complement; optional OTF_ILLEGAL_DIGIT_EN adds digit_err.
// Latency: result valid 1 cycle after the last digit. Backpressure: result held in DONE until out_ready.
// start has priority in every state and discards any digit offered in the same cycle.
module otf_sd_converter
  import otf_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int CNT_W    = $clog2(N_DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic                digit_plus,
  input  logic                digit_minus,
  output logic                in_ready,
  output logic [N_DIGITS:0]   result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
`ifdef OTF_ILLEGAL_DIGIT_EN
  ,
  output logic                digit_err
`endif
);

  localparam int W = N_DIGITS + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);

  otf_state_t       state, state_nxt;
  logic [W-1:0]     q, qm, q_nxt, qm_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       digit;
  logic             accept;

  assign digit  = {digit_plus, digit_minus};
  assign accept = in_ready && in_valid && !start;
  assign result = q;

  otf_sd_update #(.W(W)) u_update (
    .q      (q),
    .qm     (qm),
    .digit  (digit),
    .q_nxt  (q_nxt),
    .qm_nxt (qm_nxt)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: ;
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && cnt == LAST_CNT) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      qm    <= '1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        q   <= '0;
        qm  <= '1;
        cnt <= '0;
      end else if (accept) begin
        q   <= q_nxt;
        qm  <= qm_nxt;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef OTF_ILLEGAL_DIGIT_EN
  // Sticky across the whole conversion so it can be read alongside out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_err <= 1'b0;
    end else if (start) begin
      digit_err <= 1'b0;
    end else if (accept && digit == SD_ILL) begin
      digit_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_otf_sd_converter.sv
// Scoreboarded bench for otf_sd_converter at N_DIGITS=4: directed cases plus random digit streams.
module tb_otf_sd_converter;
  import otf_pkg::*;

  localparam int N = 4;
  localparam int W = N + 1;

  typedef logic [1:0] dig_arr_t [N];

  logic         clk, rst, start, in_valid, digit_plus, digit_minus;
  logic         in_ready, out_valid, out_ready, busy;
  logic [W-1:0] result;
`ifdef OTF_ILLEGAL_DIGIT_EN
  logic         digit_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] sb [$];

  otf_sd_converter #(.N_DIGITS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .digit_plus  (digit_plus),
    .digit_minus (digit_minus),
    .in_ready    (in_ready),
    .result      (result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
`ifdef OTF_ILLEGAL_DIGIT_EN
    ,
    .digit_err   (digit_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: quotient value is the weighted digit sum, wrapped into W bits.
  function automatic logic [W-1:0] model(input dig_arr_t d);
    int v = 0;
    for (int i = 0; i < N; i++) begin
      if (d[i] == SD_POS) v += (1 << (N - 1 - i));
      else if (d[i] == SD_NEG) v -= (1 << (N - 1 - i));
    end
    return W'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d);
    in_valid = 1'b1;
    {digit_plus, digit_minus} = d;
    tick();
    in_valid = 1'b0;
    {digit_plus, digit_minus} = 2'b00;
  endtask

  task automatic conv(input dig_arr_t d, input logic [W-1:0] exp, input bit exp_err,
                      input int gap_max, input int stall, input bit abort);
    tick();
    if (abort) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      send(SD_POS);
      send(SD_POS);
      // Restart with a digit on the bus that must be discarded.
      start = 1'b1;
      in_valid = 1'b1;
      {digit_plus, digit_minus} = SD_POS;
      tick();
      in_valid = 1'b0;
      {digit_plus, digit_minus} = 2'b00;
      start = 1'b0;
    end else begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    @(negedge clk);
    chk("accum_flags", {29'd0, in_ready, busy, out_valid}, 32'b110);
`ifdef OTF_ILLEGAL_DIGIT_EN
    chk("err_cleared", {31'd0, digit_err}, 32'd0);
`endif
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      send(d[i]);
    end
    sb.push_back(exp);
    @(negedge clk);
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("done_flags", {30'd0, in_ready, busy}, 32'd0);
    chk("done_result", {27'd0, result}, {27'd0, exp});
`ifdef OTF_ILLEGAL_DIGIT_EN
    chk("digit_err", {31'd0, digit_err}, {31'd0, exp_err});
`else
    if (exp_err) n_checks += 0;
`endif
    for (int s = 0; s < stall; s++) begin
      tick();
      @(negedge clk);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_result", {27'd0, result}, {27'd0, exp});
    end
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("valid_drop", {31'd0, out_valid}, 32'd0);
    chk("result_kept", {27'd0, result}, {27'd0, exp});
  endtask

  // Monitor: every handshake must match the oldest expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got result %0h with nothing expected", result);
        end else begin
          chk("sb_result", {27'd0, result}, {27'd0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    dig_arr_t d;
    bit       e;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    digit_plus = 1'b0; digit_minus = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {25'd0, in_ready, busy, out_valid, result}, 32'd0);
    tick();
    rst = 1'b0;

    // in_valid alone in IDLE must be ignored.
    send(SD_POS);
    @(negedge clk);
    chk("idle_ignore", {25'd0, in_ready, busy, out_valid, result}, 32'd0);

    d = '{SD_POS, SD_NEG, SD_ZERO, SD_POS};  conv(d, 5'b00101, 1'b0, 0, 0, 1'b0);
    d = '{SD_NEG, SD_NEG, SD_NEG, SD_NEG};   conv(d, 5'b10001, 1'b0, 0, 0, 1'b0);
    d = '{SD_POS, SD_POS, SD_POS, SD_POS};   conv(d, 5'b01111, 1'b0, 0, 1, 1'b0);
    d = '{SD_POS, SD_ZERO, SD_ZERO, SD_NEG}; conv(d, 5'b00111, 1'b0, 3, 5, 1'b0);
    d = '{SD_ZERO, SD_ZERO, SD_ZERO, SD_POS}; conv(d, 5'b00001, 1'b0, 0, 0, 1'b1);
    d = '{SD_POS, SD_ILL, SD_ZERO, SD_ZERO}; conv(d, 5'b01000, 1'b1, 1, 2, 1'b0);

    // start while DONE drops the pending result.
    tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < N; i++) send(SD_POS);
    @(negedge clk);
    chk("pre_drop_valid", {31'd0, out_valid}, 32'd1);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    chk("drop_valid", {31'd0, out_valid}, 32'd0);
    chk("drop_restart", {27'd0, busy, result}, {27'd0, 1'b1, 5'b00000});

    // Asynchronous reset mid-conversion.
    send(SD_POS);
    send(SD_NEG);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {25'd0, in_ready, busy, out_valid, result}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("post_rst_idle", {25'd0, in_ready, busy, out_valid, result}, 32'd0);

    for (int k = 0; k < 24; k++) begin
      e = 1'b0;
      for (int i = 0; i < N; i++) begin
        d[i] = 2'($urandom_range(0, 3));
        if (d[i] == SD_ILL) e = 1'b1;
      end
      conv(d, model(d), e, 2, $urandom_range(0, 3), 1'b0);
    end

    for (int t = 0; t < 50 && sb.size() != 0; t++) tick();
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: %0d results never presented, required 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
